jk_cmd_gen: RTL



---
 rtl/jk_pkg.sv | 8 +
 rtl/jk_excite_bit.sv | 14 +
 rtl/jk_cmd_gen.sv | 97 +++++++++
 3 files changed

// File: rtl/jk_pkg.sv
// jk_pkg: shared JK command codes and command-generator state encoding
package jk_pkg;
  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_RESET  = 2'b01;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_TOGGLE = 2'b11;
  typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_CHECK, ST_ERR} state_t;
endpackage

// File: rtl/jk_excite_bit.sv
// jk_excite_bit: JK excitation for one bit, present q to target t
module jk_excite_bit
  import jk_pkg::*;
(
  input  logic q,
  input  logic t,
  input  logic prefer_toggle,
  output logic j,
  output logic k
);
  logic [1:0] cmd;
  always_comb cmd = (q == t) ? JK_HOLD : prefer_toggle ? JK_TOGGLE : t ? JK_SET : JK_RESET;
  assign {j, k} = cmd;
endmodule

// File: rtl/jk_cmd_gen.sv
// jk_cmd_gen: drives a JK register bank toward a target word with bounded retries
module jk_cmd_gen
  import jk_pkg::*;
#(
  parameter int WIDTH         = 4,
  parameter int PREFER_TOGGLE = 0,
  parameter int MAX_RETRY     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] tgt_data,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             done,
  output logic             err,
  output logic [3:0]       retry_cnt
);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] tgt_q, tgt_d, j_q, j_d, k_q, k_d;
  logic [WIDTH-1:0] ex_t, ex_j, ex_k;
  logic             done_q, done_d, err_q, err_d;
  logic [3:0]       retry_q, retry_d;
  logic             accept, match;
  // Fresh commands come from the offered word on accept, from the latched target on retry
  assign ex_t   = (state_q == ST_IDLE) ? tgt_data : tgt_q;
  assign accept = tgt_valid && tgt_ready;
  assign match  = (q_fb == tgt_q);
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jk_excite_bit u_bit (
      .q             (q_fb[i]),
      .t             (ex_t[i]),
      .prefer_toggle (PREFER_TOGGLE != 0),
      .j             (ex_j[i]),
      .k             (ex_k[i])
    );
  end
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    j_d     = '0;
    k_d     = '0;
    done_d  = 1'b0;
    err_d   = err_q;
    retry_d = retry_q;
    case (state_q)
      ST_IDLE: if (accept) begin
        tgt_d   = tgt_data;
        j_d     = ex_j;
        k_d     = ex_k;
        retry_d = '0;
        state_d = ST_CMD;
      end
      ST_CMD: state_d = ST_CHECK;
      ST_CHECK: if (match) begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end else if (retry_q < 4'(MAX_RETRY)) begin
        retry_d = retry_q + 4'd1;
        j_d     = ex_j;
        k_d     = ex_k;
        state_d = ST_CMD;
      end else begin
        err_d   = 1'b1;
        state_d = ST_ERR;
      end
      default: state_d = ST_ERR;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tgt_q   <= '0;
      j_q     <= '0;
      k_q     <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      j_q     <= j_d;
      k_q     <= k_d;
      done_q  <= done_d;
      err_q   <= err_d;
      retry_q <= retry_d;
    end
  end
  assign tgt_ready = (state_q == ST_IDLE);
  assign j         = j_q;
  assign k         = k_q;
  assign done      = done_q;
  assign err       = err_q;
  assign retry_cnt = retry_q;
endmodule
